uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte FIFO write port (wr_en / din / full) between NUM_REQ requesters, e.g. the core's print path, a debug dumper and a loader acknowledger.
- Grants are message-atomic: once a requester is granted, it keeps the port until it sends a byte flagged last. Bytes from different messages never interleave on the wire.
- Round-robin fairness between messages. Sits in the clk domain directly in front of the UART transmit unit.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 1024, idle cycles mid-message before forced release; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; same clock as the UART transmit unit's write side.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  requester i presents a byte.
- req_data  in  NUM_REQ*8  byte of requester i, at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i ends its message.
- req_ready  out  NUM_REQ  byte of requester i is accepted this cycle when valid and ready are both 1.
- tx_wr_en  out  1  write strobe to the transmit FIFO.
- tx_din  out  8  byte to the transmit FIFO.
- tx_full  in  1  transmit FIFO full.
- grant_id  out  $clog2(NUM_REQ)  current or most recent grantee.
- busy  out  1  a message is in progress (state GRANT).
- timeout_err  out  1  one-cycle pulse on forced release; tied to 0 without UART_ARB_TIMEOUT_EN.

Behaviour:
- States: IDLE, GRANT.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, req_ready=0, tx_wr_en=0, tx_din=0, timeout_err=0.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register that index into grant_id and go to GRANT on the next edge.
  - Arbitration latency is 1 cycle. No transfer happens in IDLE.
- GRANT, outputs are combinational from the registered grant_id:
  - req_ready[g] = ~tx_full. All other req_ready bits are 0.
  - tx_wr_en = req_valid[g] & ~tx_full.
  - tx_din = req_data[g] when tx_wr_en is 1, otherwise 0.
  - Zero-latency pass-through. No byte is dropped or duplicated.
  - The FIFO is never written while full.
- Release:
  - Triggered by a transfer with req_last[g]=1.
  - Next state is IDLE and rr_ptr becomes (g+1) mod NUM_REQ.
  - There is at least one IDLE cycle between messages.
- Requester deasserting valid mid-message: the grant is held; the arbiter waits indefinitely, or until timeout when the optional feature is compiled in.
- Simultaneous requests in IDLE: round-robin order. Two back-to-back messages from the same requester alternate with others when those others are pending.
- tx_full asserting mid-message: req_ready drops in the same cycle, the grant is held, and transfer resumes when full deasserts.
- rst mid-message: immediate return to reset values. The partial message is abandoned and the requester restarts.
- req_valid on a non-granted requester has no effect until arbitration.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT_CYC)+1 clears on every transfer and on entering GRANT.
  - It increments each GRANT cycle with req_valid[g]=0. A cycle where tx_full=1 blocks the transfer but does not count as idle.
  - On reaching TIMEOUT_CYC: go to IDLE, rr_ptr=g+1, and timeout_err pulses 1 cycle.
- Without the macro: no counter, and timeout_err is tied to 0.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum arb_state_t {IDLE, GRANT};
  - a function for grant_id width;
  - the default TIMEOUT_CYC constant.
- Sub-module rr_pick: a combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are found and index. It is reusable for future shared resources.

Test Plan:
- Reset hold: with valid=all-ones during rst, all outputs read 0. After rst deasserts, grant_id=0 at the 2nd cycle.
- Single message: req0 sends "Hi\n" (0x48, 0x69, 0x0A, last on 0x0A) with tx_full=0. Expect tx_wr_en high 3 consecutive cycles with those bytes in order, then busy=0.
- Contention: req0 and req1 each send 2-byte messages, valid together. Expect FIFO sequence req0 b0, req0 b1, gap, req1 b0, req1 b1, with no interleave. Repeat the pair: order is still req0 then req1 because rr_ptr wrapped.
- Backpressure: tx_full=1 for 5 cycles mid-message. Expect req_ready=0 and tx_wr_en=0 throughout, then resume with the next byte and no loss or duplication.
- Timeout (macro on, TIMEOUT_CYC=16): req1 sends 1 non-last byte, then valid=0. Expect timeout_err pulse and busy=0 16 cycles after the last transfer, then req0 is granted. With the macro off, busy remains 1 indefinitely.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit-port arbiter.
// Optional build macro in the arbiter: UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYC = 1024;

    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the transmit FIFO write port.
// master drives requests and FIFO status, slave is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_wr_en;
    logic [7:0]           tx_din;
    logic                 tx_full;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_wr_en, tx_din
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_wr_en, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after
// ptr, wrapping modulo N.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = gid_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // rot[k] is the request that sits k places after ptr
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        int s;
        s     = 0;
        found = |req;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                s = int'(ptr) + k;
                if (s >= N)
                    s = s - N;
                idx = W'(s);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter for the UART transmit FIFO port.
// Define UART_ARB_TIMEOUT_EN to force release of a stalled message.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 2,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int GW          = gid_w(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              timeout_err
);
    localparam logic [0:0] S_IDLE  = 1'(IDLE);
    localparam logic [0:0] S_GRANT = 1'(GRANT);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameters");
    end

    logic [0:0]    state;
    logic [GW-1:0] rr_ptr;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic          in_grant;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          xfer;
    logic          tmo_hit;
    logic          rel;
    logic [GW-1:0] next_ptr;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*8 +: 8];
            end
        end
    end

    assign in_grant = (state == S_GRANT);
    assign xfer     = in_grant & g_valid & ~bus.tx_full;
    assign busy     = in_grant;

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (in_grant && grant_id == GW'(i))
                bus.req_ready[i] = ~bus.tx_full;
        end
    end

    assign bus.tx_wr_en = xfer;
    assign bus.tx_din   = xfer ? g_data : 8'h00;

    assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0
                    : grant_id + GW'(1);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] idle_cnt;

    // Backpressure stalls do not count towards the idle budget
    assign tmo_hit = in_grant & ~g_valid & ~bus.tx_full
                   & (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst)
            idle_cnt <= '0;
        else if (!in_grant || xfer)
            idle_cnt <= '0;
        else if (!g_valid && !bus.tx_full)
            idle_cnt <= idle_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            timeout_err <= 1'b0;
        else
            timeout_err <= tmo_hit;
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign rel = (xfer & g_last) | tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= S_GRANT;
                    end
                end
                in_grant: begin
                    if (rel) begin
                        state  <= S_IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios plus
// randomized multi-requester traffic against a message-level model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 16;
    localparam int GW  = gid_w(N);

    typedef struct {
        logic [7:0] data;
        logic       last;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [GW-1:0] grant_id;
    logic          busy;
    logic          timeout_err;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    ent_t       src[N][$];
    ent_t       exp_q[N][$];
    logic [7:0] wlog[$];
    int         wcyc[$];

    bit         mon_on     = 1'b0;
    bit         force_full = 1'b0;
    int         vprob      = 100;
    int         fprob      = 0;

    logic [N-1:0] hs         = '0;
    logic [N-1:0] prev_valid = '0;
    bit           prev_busy  = 1'b0;
    bit           rel_pend   = 1'b0;
    bit           forced     = 1'b0;
    int           owner      = 0;
    int           ptr        = 0;
    int           cyc        = 0;
    int           xfer_cyc   = 0;
    int           frel_cyc   = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Message-level round robin: first waiting requester at or after p
    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N])
                return (p + k) % N;
        return -1;
    endfunction

    function automatic bit idle_all();
        int s = 0;
        for (int i = 0; i < N; i++)
            s += src[i].size();
        return (s == 0) && !busy;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst || !mon_on) begin
            hs         = '0;
            prev_valid = '0;
            prev_busy  = 1'b0;
            rel_pend   = 1'b0;
            ptr        = 0;
            owner      = 0;
            frel_cyc   = 0;
        end else begin
            hs     = bus.req_valid & bus.req_ready;
            forced = prev_busy && !busy && !rel_pend;
            if (rel_pend)
                chk("release_after_last", busy, 0);
`ifdef UART_ARB_TIMEOUT_EN
            chk("timeout_err", timeout_err, forced);
            if (forced) begin
                ptr      = (owner + 1) % N;
                frel_cyc = cyc;
            end
`else
            chk("no_forced_release", forced, 0);
            chk("timeout_err", timeout_err, 0);
`endif
            rel_pend = 1'b0;
            if (busy && !prev_busy) begin
                owner = pick(ptr, prev_valid);
                chk("grant_id", grant_id, owner);
                if (owner < 0)
                    owner = 0;
            end
            if (busy)
                chk("req_ready", bus.req_ready, bus.tx_full ? 0 : (1 << owner));
            else
                chk("req_ready_idle", bus.req_ready, 0);
            chk("tx_wr_en", bus.tx_wr_en,
                busy && bus.req_valid[owner] && !bus.tx_full);
            if (bus.tx_wr_en) begin
                chk("byte_expected", exp_q[owner].size() > 0, 1);
                if (exp_q[owner].size() > 0) begin
                    ent_t e;
                    e = exp_q[owner].pop_front();
                    chk("tx_din", bus.tx_din, e.data);
                    if (e.last) begin
                        rel_pend = 1'b1;
                        ptr      = (owner + 1) % N;
                    end
                end
                wlog.push_back(bus.tx_din);
                wcyc.push_back(cyc);
                xfer_cyc = cyc;
            end else begin
                chk("tx_din_idle", bus.tx_din, 0);
            end
            prev_valid = bus.req_valid;
            prev_busy  = busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i])
                void'(src[i].pop_front());
            if (!(bus.req_valid[i] && !hs[i])) begin
                if (src[i].size() > 0 && $urandom_range(99) < vprob) begin
                    bus.req_valid[i]        = 1'b1;
                    bus.req_data[i*8 +: 8]  = src[i][0].data;
                    bus.req_last[i]         = src[i][0].last;
                end else begin
                    bus.req_valid[i]        = 1'b0;
                    bus.req_data[i*8 +: 8]  = 8'h00;
                    bus.req_last[i]         = 1'b0;
                end
            end
        end
        bus.tx_full = force_full || ($urandom_range(99) < fprob);
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic l);
        ent_t e;
        e.data = d;
        e.last = l;
        src[r].push_back(e);
        exp_q[r].push_back(e);
    endtask

    task automatic do_reset();
        mon_on        = 1'b0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_full   = 1'b0;
        force_full    = 1'b0;
        for (int i = 0; i < N; i++) begin
            src[i].delete();
            exp_q[i].delete();
        end
        wlog.delete();
        wcyc.delete();
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = idle_all();
        end
        chk("drain_done", done, 1);
        repeat (2) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hi[3];
        logic [7:0] ce[8];
        int nb;
        int n;
        int added;
        int total;
        hi = '{8'h48, 8'h69, 8'h0A};
        ce = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};

        // Reset hold with every requester asking
        bus.req_valid = '1;
        bus.req_data  = 24'h5A5A5A;
        bus.req_last  = '0;
        bus.tx_full   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", bus.tx_wr_en, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_din", bus.tx_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arb_cycle_busy", busy, 0);
        @(negedge clk);
        chk("first_grant_busy", busy, 1);
        chk("first_grant_id", grant_id, 0);

        // "Hi\n" from requester 0
        do_reset();
        for (int k = 0; k < 3; k++)
            add_byte(0, hi[k], k == 2);
        drain(50);
        chk("hi_count", wlog.size(), 3);
        for (int k = 0; k < 3 && k < wlog.size(); k++)
            chk("hi_byte", wlog[k], hi[k]);
        if (wcyc.size() == 3)
            chk("hi_back_to_back", wcyc[2] - wcyc[0], 2);
        chk("hi_busy_after", busy, 0);

        // Two requesters, two messages each, all pending together
        do_reset();
        add_byte(0, ce[0], 0); add_byte(0, ce[1], 1);
        add_byte(1, ce[2], 0); add_byte(1, ce[3], 1);
        add_byte(0, ce[4], 0); add_byte(0, ce[5], 1);
        add_byte(1, ce[6], 0); add_byte(1, ce[7], 1);
        drain(100);
        chk("cont_count", wlog.size(), 8);
        for (int k = 0; k < 8 && k < wlog.size(); k++)
            chk("cont_order", wlog[k], ce[k]);
        if (wcyc.size() >= 3)
            chk("cont_gap", (wcyc[2] - wcyc[1]) >= 2, 1);

        // FIFO full for 5 cycles in the middle of a message
        do_reset();
        for (int k = 0; k < 4; k++)
            add_byte(0, 8'(8'h10 + k), k == 3);
        n = 0;
        while (wlog.size() < 1 && n < 50) begin
            step();
            n++;
        end
        chk("bp_first_byte", wlog.size(), 1);
        force_full = 1'b1;
        step();
        nb = wlog.size();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_wr_en", bus.tx_wr_en, 0);
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_busy", busy, 1);
            if (k < 4)
                step();
        end
        chk("bp_no_write", wlog.size(), nb);
        force_full = 1'b0;
        drain(50);
        chk("bp_count", wlog.size(), 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++)
            chk("bp_byte", wlog[k], 8'(8'h10 + k));

        // Randomized traffic from all requesters with backpressure
        do_reset();
        vprob = 70;
        fprob = 25;
        added = 0;
        total = 0;
        for (int c = 0; c < 8000 && !(added == 60 && idle_all()); c++) begin
            if (added < 60 && $urandom_range(99) < 20) begin
                int r;
                int len;
                r   = $urandom_range(N - 1);
                len = $urandom_range(5, 1);
                for (int k = 0; k < len; k++)
                    add_byte(r, 8'($urandom), k == len - 1);
                added++;
                total += len;
            end
            step();
        end
        chk("rand_drained", idle_all(), 1);
        repeat (2) step();
        chk("rand_bytes", wlog.size(), total);
        vprob = 100;
        fprob = 0;

        // Requester 1 stalls mid-message
        do_reset();
        add_byte(1, 8'h55, 1'b0);
        n = 0;
        while (wlog.size() < 1 && n < 20) begin
            step();
            n++;
        end
        chk("stall_byte", wlog.size(), 1);
`ifdef UART_ARB_TIMEOUT_EN
        add_byte(0, 8'h66, 1'b1);
        n = 0;
        while (frel_cyc == 0 && n < 100) begin
            step();
            n++;
        end
        chk("tmo_released", frel_cyc != 0, 1);
        chk("tmo_delay", frel_cyc - xfer_cyc, TMO + 1);
        drain(50);
        chk("tmo_next_count", wlog.size(), 2);
        if (wlog.size() == 2)
            chk("tmo_next_byte", wlog[1], 8'h66);
`else
        add_byte(0, 8'h66, 1'b1);
        repeat (3 * TMO) step();
        @(negedge clk);
        chk("stall_busy", busy, 1);
        chk("stall_grant", grant_id, 1);
        chk("stall_no_write", wlog.size(), 1);
`endif
        do_reset();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
